// File: rtl/dmux_4_8way_reg.sv
// Registered 1-to-4 and 1-to-8 demultiplexers sharing one data input and select bus.
// Unselected outputs are driven to zero; every output updates one cycle after sampling.
module dmux_4_8way_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] l
);

    logic [WIDTH-1:0] out4_d [4];
    logic [WIDTH-1:0] out4_q [4];
    logic [WIDTH-1:0] out8_d [8];
    logic [WIDTH-1:0] out8_q [8];

    // The 4-way section only looks at sel[1:0], so sel 4..7 alias onto a..d.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            out4_d[n] = (sel[1:0] == 2'(n)) ? in : '0;
        end
        for (int n = 0; n < 8; n++) begin
            out8_d[n] = (sel == 3'(n)) ? in : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) begin
                out4_q[n] <= '0;
            end
            for (int n = 0; n < 8; n++) begin
                out8_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                out4_q[n] <= out4_d[n];
            end
            for (int n = 0; n < 8; n++) begin
                out8_q[n] <= out8_d[n];
            end
        end
    end

    assign a = out4_q[0];
    assign b = out4_q[1];
    assign c = out4_q[2];
    assign d = out4_q[3];
    assign e = out8_q[0];
    assign f = out8_q[1];
    assign g = out8_q[2];
    assign h = out8_q[3];
    assign i = out8_q[4];
    assign j = out8_q[5];
    assign k = out8_q[6];
    assign l = out8_q[7];

endmodule

// File: tb/tb_dmux_4_8way_reg.sv
// Table-driven bench for dmux_4_8way_reg at WIDTH=8, plus directed reset and latency sequences.
module tb_dmux_4_8way_reg;

    localparam int unsigned W = 8;

    typedef struct {
        string      name;
        logic [7:0] din;
        logic [2:0] sel;
        logic [31:0] e4;  // {d,c,b,a}
        logic [63:0] e8;  // {l,k,j,i,h,g,f,e}
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_s;
    logic [2:0]   sel_s;
    logic [W-1:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s, i_s, j_s, k_s, l_s;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    dmux_4_8way_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_s),
        .sel   (sel_s),
        .a     (a_s),
        .b     (b_s),
        .c     (c_s),
        .d     (d_s),
        .e     (e_s),
        .f     (f_s),
        .g     (g_s),
        .h     (h_s),
        .i     (i_s),
        .j     (j_s),
        .k     (k_s),
        .l     (l_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] e4, input logic [63:0] e8);
        logic [31:0] got4;
        logic [63:0] got8;
        got4 = {d_s, c_s, b_s, a_s};
        got8 = {l_s, k_s, j_s, i_s, h_s, g_s, f_s, e_s};
        checks++;
        if (got4 !== e4 || got8 !== e8) begin
            errors++;
            $display("FAIL %s: got dcba=%h lkjihgfe=%h, expected dcba=%h lkjihgfe=%h",
                     name, got4, got8, e4, e8);
        end
    endtask

    task automatic add(input string name, input logic [7:0] din, input logic [2:0] sel,
                       input logic [31:0] e4, input logic [63:0] e8);
        vec_t v;
        v.name = name; v.din = din; v.sel = sel; v.e4 = e4; v.e8 = e8;
        vecs.push_back(v);
    endtask

    initial begin
        // in=0 sweep: everything zero regardless of sel
        for (int s = 0; s < 8; s++) add($sformatf("zero_sel%0d", s), 8'h00, 3'(s), 32'h0, 64'h0);
        // in=1 sweep
        add("one_sel0", 8'h01, 3'd0, 32'h0000_0001, 64'h0000_0000_0000_0001);
        add("one_sel1", 8'h01, 3'd1, 32'h0000_0100, 64'h0000_0000_0000_0100);
        add("one_sel2", 8'h01, 3'd2, 32'h0001_0000, 64'h0000_0000_0001_0000);
        add("one_sel3", 8'h01, 3'd3, 32'h0100_0000, 64'h0000_0000_0100_0000);
        add("one_sel4", 8'h01, 3'd4, 32'h0000_0001, 64'h0000_0001_0000_0000);
        add("one_sel5", 8'h01, 3'd5, 32'h0000_0100, 64'h0000_0100_0000_0000);
        add("one_sel6", 8'h01, 3'd6, 32'h0001_0000, 64'h0001_0000_0000_0000);
        add("one_sel7", 8'h01, 3'd7, 32'h0100_0000, 64'h0100_0000_0000_0000);
        // wide data with 7->0 wrap
        add("wide_sel6", 8'hA5, 3'd6, 32'h00A5_0000, 64'h00A5_0000_0000_0000);
        add("wide_sel7", 8'hA5, 3'd7, 32'hA500_0000, 64'hA500_0000_0000_0000);
        add("wide_sel0", 8'hA5, 3'd0, 32'h0000_00A5, 64'h0000_0000_0000_00A5);
        add("simul_chg", 8'h3C, 3'd5, 32'h0000_3C00, 64'h0000_3C00_0000_0000);

        // Reset held: clock toggles must not load anything
        rst_n = 1'b0; in_s = 8'h01; sel_s = 3'd5;
        repeat (3) @(posedge clk);
        #1 check("reset_hold", 32'h0, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("reset_release_noedge", 32'h0, 64'h0);
        @(posedge clk); #1;
        check("reset_first_edge", 32'h0000_0100, 64'h0000_0100_0000_0000);

        foreach (vecs[n]) begin
            @(negedge clk);
            in_s = vecs[n].din; sel_s = vecs[n].sel;
            @(posedge clk); #1;
            check(vecs[n].name, vecs[n].e4, vecs[n].e8);
        end

        // Latency: sel change mid-cycle only takes effect at the next edge
        @(negedge clk); in_s = 8'h01; sel_s = 3'd2;
        @(posedge clk); #1 check("lat_sel2", 32'h0001_0000, 64'h0000_0000_0001_0000);
        @(negedge clk); sel_s = 3'd6;
        #1 check("lat_hold", 32'h0001_0000, 64'h0000_0000_0001_0000);
        @(posedge clk); #1 check("lat_sel6", 32'h0001_0000, 64'h0001_0000_0000_0000);

        // Async reset between edges clears outputs without a clock
        @(negedge clk); sel_s = 3'd3;
        @(posedge clk); #1 check("async_pre", 32'h0100_0000, 64'h0000_0000_0100_0000);
        #2 rst_n = 1'b0;
        #1 check("async_clear", 32'h0, 64'h0);
        @(posedge clk); #1 check("async_hold", 32'h0, 64'h0);
        @(negedge clk); rst_n = 1'b1; in_s = 8'h5A; sel_s = 3'd4;
        @(posedge clk); #1 check("async_fresh", 32'h0000_005A, 64'h0000_005A_0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
